// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit : CPU load/store sequencer for a 64-bit word data memory
// Rev 1.0
// ============================================================================
module load_store_unit #(
   parameter int WAIT_CYCLES = 1,
   parameter int SIZE        = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [63:0] addr,
   input  logic [63:0] wdata,
   output logic        ready,
   output logic        done,
   output logic        err,
   output logic [63:0] rdata,
   output logic [63:0] mem_address,
   output logic [63:0] mem_InData,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [63:0] mem_outRead
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR      = 2'd2,
      RESP    = 2'd3
   } state_t;

   localparam logic [63:0] c_size      = 64'(SIZE);
   localparam logic [3:0]  c_wait_load = 4'(WAIT_CYCLES - 1);

   state_t     r_state;
   logic [3:0] r_cnt;
   logic       r_done;
   logic       r_err;
   logic [63:0] r_rdata;
   logic [63:0] r_addr;
   logic [63:0] r_wdata;

   // Strobes and ready come straight off the state register, never from inputs.
   assign ready       = (r_state == IDLE);
   assign mem_read    = (r_state == RD_WAIT);
   assign mem_write   = (r_state == WR);
   assign done        = r_done;
   assign err         = r_err;
   assign rdata       = r_rdata;
   assign mem_address = r_addr;
   assign mem_InData  = r_wdata;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= 64'd0;
         r_addr  <= 64'd0;
         r_wdata <= 64'd0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               r_err  <= 1'b0;
               if (req) begin
                  r_addr  <= addr;
                  r_wdata <= wdata;
                  // The operation type is carried forward by the next state.
                  if (addr >= c_size) begin
                     r_state <= RESP;
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                  end else if (we) begin
                     r_state <= WR;
                  end else begin
                     r_state <= RD_WAIT;
                     r_cnt   <= c_wait_load;
                  end
               end
            end
            RD_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_rdata <= mem_outRead;
                  r_state <= RESP;
                  r_done  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            WR: begin
               r_state <= RESP;
               r_done  <= 1'b1;
            end
            RESP: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_err   <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_err   <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// tb_load_store_unit : directed bench, DUT 0 with WAIT_CYCLES=1, DUT 1 with 3
// Rev 1.0
// ============================================================================
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n [2];
   logic        req   [2];
   logic        we    [2];
   logic [63:0] addr  [2];
   logic [63:0] wdata [2];
   logic        ready [2];
   logic        done  [2];
   logic        err   [2];
   logic [63:0] rdata [2];
   logic [63:0] mem_address [2];
   logic [63:0] mem_InData  [2];
   logic        mem_read    [2];
   logic        mem_write   [2];
   logic [63:0] mem_outRead [2];
   logic [63:0] mem [2][32];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      load_store_unit #(
         .WAIT_CYCLES(g == 0 ? 1 : 3),
         .SIZE       (32)
      ) u_dut (
         .clk        (clk),
         .rst_n      (rst_n[g]),
         .req        (req[g]),
         .we         (we[g]),
         .addr       (addr[g]),
         .wdata      (wdata[g]),
         .ready      (ready[g]),
         .done       (done[g]),
         .err        (err[g]),
         .rdata      (rdata[g]),
         .mem_address(mem_address[g]),
         .mem_InData (mem_InData[g]),
         .mem_read   (mem_read[g]),
         .mem_write  (mem_write[g]),
         .mem_outRead(mem_outRead[g])
      );

      assign mem_outRead[g] = (mem_address[g] < 64'd32) ? mem[g][mem_address[g][4:0]] : 64'd0;

      always @(posedge clk)
         if (mem_write[g] && mem_address[g] < 64'd32)
            mem[g][mem_address[g][4:0]] <= mem_InData[g];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one request from an IDLE negedge and follow it to the done cycle.
   task automatic op(input int d, input logic w, input logic [63:0] a, input logic [63:0] wd,
                     input int lat, input logic e, input int nrd, input int nwr);
      int k;
      int rds;
      int wrs;
      int nrdy;
      k = 1; rds = 0; wrs = 0; nrdy = 0;
      chk("ready_before_accept", ready[d], 1'b1);
      req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
      @(negedge clk);
      req[d] = 1'b0; addr[d] = 64'h5A5A; wdata[d] = 64'h0;
      while (!done[d] && k < 20) begin
         rds += int'(mem_read[d]);
         wrs += int'(mem_write[d]);
         nrdy += int'(ready[d]);
         @(negedge clk);
         k++;
      end
      chk("latency", 64'(k), 64'(lat));
      chk("err_with_done", err[d], e);
      chk("ready_low_in_resp", ready[d], 1'b0);
      chk("ready_during_op", 64'(nrdy), 64'd0);
      chk("read_cycles", 64'(rds), 64'(nrd));
      chk("write_cycles", 64'(wrs), 64'(nwr));
      chk("addr_latched", mem_address[d], a);
      @(negedge clk);
      chk("done_one_cycle", done[d], 1'b0);
      chk("err_cleared", err[d], 1'b0);
      chk("ready_after_resp", ready[d], 1'b1);
   endtask

   initial begin
      int n_rdy;
      int n_done;
      int n_rd;
      int n_wr;
      int n_ovl;
      for (int d = 0; d < 2; d++) begin
         rst_n[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0;
         addr[d] = 64'd0; wdata[d] = 64'd0;
         for (int j = 0; j < 32; j++) mem[d][j] = 64'(j);
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_ready", ready[d], 1'b1);
         chk("rst_done", done[d], 1'b0);
         chk("rst_err", err[d], 1'b0);
         chk("rst_rdata", rdata[d], 64'd0);
         chk("rst_mem_address", mem_address[d], 64'd0);
         chk("rst_mem_InData", mem_InData[d], 64'd0);
         chk("rst_mem_read", mem_read[d], 1'b0);
         chk("rst_mem_write", mem_write[d], 1'b0);
         rst_n[d] = 1'b1;
      end
      @(negedge clk);

      // Store then load on the single-wait unit.
      op(0, 1'b1, 64'd5, 64'hDEAD_BEEF, 2, 1'b0, 0, 1);
      chk("mem5_written", mem[0][5], 64'hDEAD_BEEF);
      chk("rdata_after_store", rdata[0], 64'd0);
      chk("InData_held", mem_InData[0], 64'hDEAD_BEEF);
      op(0, 1'b0, 64'd5, 64'd0, 2, 1'b0, 1, 0);
      chk("rdata_load5", rdata[0], 64'hDEAD_BEEF);

      // Out-of-range requests are rejected without touching memory or rdata.
      op(0, 1'b0, 64'd32, 64'd0, 1, 1'b1, 0, 0);
      chk("rdata_after_rej32", rdata[0], 64'hDEAD_BEEF);
      op(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1111, 1, 1'b1, 0, 0);
      chk("rdata_after_rej_max", rdata[0], 64'hDEAD_BEEF);
      op(0, 1'b0, 64'd31, 64'd0, 2, 1'b0, 1, 0);
      chk("rdata_load31", rdata[0], 64'd31);

      // Three-cycle wait load.
      op(1, 1'b0, 64'd7, 64'd0, 4, 1'b0, 3, 0);
      chk("rdata_load7", rdata[1], 64'd7);

      // Back-to-back requests with req held and we alternating each operation.
      n_rdy = 0; n_done = 0; n_rd = 0; n_wr = 0; n_ovl = 0;
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 64'd3; wdata[0] = 64'h1234;
      for (int i = 0; i < 12; i++) begin
         n_rdy  += int'(ready[0]);
         n_rd   += int'(mem_read[0]);
         n_wr   += int'(mem_write[0]);
         n_ovl  += int'(mem_read[0] && mem_write[0]);
         if (done[0]) begin
            n_done++;
            we[0] = ~we[0];
         end
         @(negedge clk);
      end
      req[0] = 1'b0;
      chk("stream_accepts", 64'(n_rdy), 64'd4);
      chk("stream_dones", 64'(n_done), 64'd4);
      chk("stream_reads", 64'(n_rd), 64'd2);
      chk("stream_writes", 64'(n_wr), 64'd2);
      chk("stream_overlap", 64'(n_ovl), 64'd0);
      chk("stream_rdata", rdata[0], 64'h1234);
      chk("stream_ready_end", ready[0], 1'b1);

      // Reset during the second wait cycle of a load.
      req[1] = 1'b1; we[1] = 1'b0; addr[1] = 64'd12; wdata[1] = 64'd0;
      @(negedge clk);
      req[1] = 1'b0;
      chk("abort_rd_wait1", mem_read[1], 1'b1);
      @(negedge clk);
      chk("abort_rd_wait2", mem_read[1], 1'b1);
      rst_n[1] = 1'b0;
      req[1] = 1'b1;
      @(negedge clk);
      chk("abort_ready", ready[1], 1'b1);
      chk("abort_mem_read", mem_read[1], 1'b0);
      chk("abort_done", done[1], 1'b0);
      chk("abort_rdata", rdata[1], 64'd0);
      req[1] = 1'b0;
      rst_n[1] = 1'b1;
      @(negedge clk);
      chk("abort_no_late_done", done[1], 1'b0);
      chk("abort_still_idle", ready[1], 1'b1);
      op(1, 1'b0, 64'd9, 64'd0, 4, 1'b0, 3, 0);
      chk("rdata_load9", rdata[1], 64'd9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
